btc_nonce_sequencer: RTL



---
 rtl/btc_miner_pkg.sv | 17 +
 rtl/btc_nonce_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/btc_miner_pkg.sv
// Definitions shared between the miner register block and the nonce sequencer:
// sequencer state encoding, default nonce width and status register bit positions.
package btc_miner_pkg;

   localparam int unsigned NonceWDefault = 32;

   typedef logic [1:0] state_t;

   localparam state_t StIdle  = 2'd0;
   localparam state_t StIssue = 2'd1;
   localparam state_t StWait  = 2'd2;
   localparam state_t StDrain = 2'd3;

   localparam int unsigned StatusDoneBit  = 0;
   localparam int unsigned StatusFoundBit = 1;

endpackage

// File: rtl/btc_nonce_sequencer.sv
// Issues nonces one at a time to the SHA-256d core over req/ack and folds each
// hit/miss result into sticky done / nonce_found status plus the last tested nonce.
module btc_nonce_sequencer
   import btc_miner_pkg::*;
#(
   parameter int unsigned          NONCE_W    = NonceWDefault,
   parameter logic [NONCE_W-1:0]   NONCE_STEP = 1,
   parameter logic [NONCE_W-1:0]   NONCE_BASE = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               config_use_nonce_in,
   input  logic               config_oneshot,
   input  logic [NONCE_W-1:0] nonce_in,
   output logic               hash_req,
   output logic [NONCE_W-1:0] hash_nonce,
   input  logic               hash_ack,
   input  logic               hash_res_valid,
   input  logic               hash_hit,
   output logic               busy,
   output logic [NONCE_W-1:0] nonce,
   output logic               done,
   output logic               nonce_found
);

   state_t             state_q, state_d;
   logic [NONCE_W-1:0] cur_q, cur_d;
   logic [NONCE_W-1:0] nonce_q, nonce_d;
   logic               oneshot_q, oneshot_d;
   logic               req_q, req_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               found_q, found_d;
   logic [NONCE_W:0]   next_sum;
   logic [NONCE_W-1:0] load_val;

   assign load_val = config_use_nonce_in ? nonce_in : NONCE_BASE;
   // Extra bit catches the carry that marks nonce space exhaustion.
   assign next_sum = {1'b0, cur_q} + {1'b0, NONCE_STEP};

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      nonce_d   = nonce_q;
      oneshot_d = oneshot_q;
      req_d     = req_q;
      done_d    = done_q;
      found_d   = found_q;

      if (start) begin
         cur_d     = load_val;
         oneshot_d = config_oneshot;
         done_d    = 1'b0;
         found_d   = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StIssue;
               req_d   = 1'b1;
            end
         end
         StIssue: begin
            // A restart leaves one idle request cycle before the reloaded nonce goes out.
            if (start) begin
               req_d = 1'b0;
            end else if (req_q && hash_ack) begin
               req_d   = 1'b0;
               state_d = StWait;
            end else begin
               req_d = 1'b1;
            end
         end
         StWait: begin
            if (start) begin
               // A coincident result is consumed here, so nothing is left to drain.
               state_d = hash_res_valid ? StIssue : StDrain;
               req_d   = hash_res_valid;
            end else if (hash_res_valid) begin
               nonce_d = cur_q;
               if (hash_hit) begin
                  found_d = 1'b1;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else if (oneshot_q || next_sum[NONCE_W]) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  cur_d   = next_sum[NONCE_W-1:0];
                  req_d   = 1'b1;
                  state_d = StIssue;
               end
            end
         end
         StDrain: begin
            if (hash_res_valid) begin
               req_d   = 1'b1;
               state_d = StIssue;
            end
         end
         default: begin
            state_d = StIdle;
            req_d   = 1'b0;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cur_q     <= '0;
         nonce_q   <= '0;
         oneshot_q <= 1'b0;
         req_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         found_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         nonce_q   <= nonce_d;
         oneshot_q <= oneshot_d;
         req_q     <= req_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         found_q   <= found_d;
      end
   end

   assign hash_req    = req_q;
   assign hash_nonce  = cur_q;
   assign busy        = busy_q;
   assign nonce       = nonce_q;
   assign done        = done_q;
   assign nonce_found = found_q;

endmodule
